// File: rtl/vc_uart_pkg.sv
// Shared constants and sequencer state encoding for the UART transmit queue.
package vc_uart_pkg;

    localparam int unsigned BYTE_W               = 8;
    localparam int unsigned DEFAULT_DEPTH_LOG2   = 4;
    localparam int unsigned DEFAULT_BUSY_LATENCY = 2;

    // Transmit sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        HOLDOFF = 2'd2,
        DRAIN   = 2'd3
    } txState_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with registered full/empty/count.
// A pop frees a slot in the same cycle, so push-while-full is accepted when paired with a pop.
module sync_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      pushData,
    input  logic                  pop,
    output logic [WIDTH-1:0]      popData,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int unsigned         DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [DEPTH_LOG2:0]   countNext;
    logic                  doPush;
    logic                  doPop;

    assign popData = mem[rptr];

    // Qualify requests: pop needs data, push needs a free slot or a concurrent pop.
    always_comb begin
        doPop     = pop && !empty;
        doPush    = push && (!full || doPop);
        countNext = count;
        case ({doPush, doPop})
            2'b10:   countNext = count + 1'b1;
            2'b01:   countNext = count - 1'b1;
            default: countNext = count;
        endcase
    end

    // Storage write; contents need no reset since pointers/count define validity.
    always_ff @(posedge clk) begin
        if (!rst && doPush) begin
            mem[wptr] <= pushData;
        end
    end

    // Pointers, occupancy and the flags derived from the next occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (doPush) wptr <= wptr + 1'b1;
            if (doPop)  rptr <= rptr + 1'b1;
            count <= countNext;
            full  <= (countNext == FULL_COUNT);
            empty <= (countNext == '0);
        end
    end

    assert property (@(posedge clk) disable iff (rst) count <= FULL_COUNT);
    assert property (@(posedge clk) disable iff (rst) full == (count == FULL_COUNT));
    assert property (@(posedge clk) disable iff (rst) empty == (count == '0));

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue in front of the UART transmitter: buffers pushed bytes and
// launches them one at a time whenever the transmitter reports idle.
module uart_tx_queue
    import vc_uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2   = DEFAULT_DEPTH_LOG2,
    parameter int unsigned BUSY_LATENCY = DEFAULT_BUSY_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pushValid,
    input  logic [BYTE_W-1:0]     pushData,
    input  logic                  txBusy,
    output logic                  txStart,
    output logic [BYTE_W-1:0]     txData,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam int unsigned HOLD_W = (BUSY_LATENCY < 2) ? 1 : $clog2(BUSY_LATENCY + 1);

    txState_t          state;
    txState_t          stateNext;
    logic [HOLD_W-1:0] holdCnt;
    logic              fifoPop;
    logic [BYTE_W-1:0] fifoData;

    sync_fifo #(
        .WIDTH      (BYTE_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) uFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (pushValid),
        .pushData (pushData),
        .pop      (fifoPop),
        .popData  (fifoData),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // Next-state logic; txBusy is ignored during HOLDOFF because the transmitter's
    // busy flag is not yet guaranteed to reflect the byte just launched.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (!empty && !txBusy) stateNext = LAUNCH;
            LAUNCH:  stateNext = HOLDOFF;
            HOLDOFF: if (holdCnt <= HOLD_W'(1)) stateNext = DRAIN;
            DRAIN:   if (!txBusy) stateNext = empty ? IDLE : LAUNCH;
            default: stateNext = IDLE;
        endcase
    end

    // Outputs decoded from the current state: LAUNCH issues the start pulse and pops.
    always_comb begin
        txStart = 1'b0;
        fifoPop = 1'b0;
        if (state == LAUNCH) begin
            txStart = 1'b1;
            fifoPop = 1'b1;
        end
    end

    // Holdoff counter: loaded on LAUNCH, counted down through HOLDOFF.
    always_ff @(posedge clk) begin
        if (rst) begin
            holdCnt <= '0;
        end else if (state == LAUNCH) begin
            holdCnt <= HOLD_W'(BUSY_LATENCY);
        end else if (state == HOLDOFF && holdCnt != '0) begin
            holdCnt <= holdCnt - 1'b1;
        end
    end

    // txData is captured on entry to LAUNCH so it is already valid while txStart
    // is high; the head entry cannot change in that cycle because no pop occurs.
    always_ff @(posedge clk) begin
        if (rst) begin
            txData <= '0;
        end else if (stateNext == LAUNCH && state != LAUNCH) begin
            txData <= fifoData;
        end
    end

    // Sticky overflow: a push is dropped only when full and no pop frees a slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (pushValid && full && !fifoPop) begin
            overflow <= 1'b1;
        end
    end

    assert property (@(posedge clk) disable iff (rst) txStart |=> !txStart);
    assert property (@(posedge clk) disable iff (rst) (state == LAUNCH) |-> !empty);

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed testbench for uart_tx_queue with a simple transmitter busy model.
module tb_uart_tx_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       pushValid;
    logic [7:0] pushData;
    logic       txBusy;
    logic       txStart;
    logic [7:0] txData;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pushCyc;

    // Transmitter model: busy for modelLen cycles after each sampled start, plus manual force.
    int   modelLen = 0;
    int   modelCnt = 0;
    logic busyForce;

    // Start-pulse log filled by the monitor.
    logic [7:0] startData[$];
    int         startCyc[$];
    logic       startPrevBusy[$];
    logic       prevBusy = 1'b0;

    uart_tx_queue #(
        .DEPTH_LOG2   (4),
        .BUSY_LATENCY (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pushValid (pushValid),
        .pushData  (pushData),
        .txBusy    (txBusy),
        .txStart   (txStart),
        .txData    (txData),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (txStart)           modelCnt <= modelLen;
        else if (modelCnt > 0) modelCnt <= modelCnt - 1;
    end

    assign txBusy = busyForce | (modelCnt != 0);

    always @(negedge clk) begin
        if (txStart) begin
            startData.push_back(txData);
            startCyc.push_back(cyc);
            startPrevBusy.push_back(prevBusy);
        end
        prevBusy = txBusy;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clearLog;
        startData.delete();
        startCyc.delete();
        startPrevBusy.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1; pushValid = 1'b0; pushData = 8'h00; busyForce = 1'b0; modelLen = 0;
        repeat (2) tick;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (txStart !== 1'b0) begin errors++; $display("FAIL reset_txStart: got %b want 0", txStart); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (txData !== 8'h00) begin errors++; $display("FAIL reset_txData: got %h want 00", txData); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        clearLog;
        repeat (10) tick;
        checks++; if (startData.size() != 0) begin errors++; $display("FAIL idle_no_start: got %0d starts want 0", startData.size()); end
    endtask

    task automatic test_single;
        clearLog;
        modelLen = 87;
        tick;
        pushValid = 1'b1; pushData = 8'h41; pushCyc = cyc;
        tick;
        pushValid = 1'b0;
        repeat (100) tick;
        checks++;
        if (startData.size() != 1) begin
            errors++; $display("FAIL single_count: got %0d starts want 1", startData.size());
        end else begin
            checks++; if (startData[0] !== 8'h41) begin errors++; $display("FAIL single_data: got %h want 41", startData[0]); end
            checks++; if (startCyc[0] - pushCyc != 2) begin errors++; $display("FAIL single_latency: got %0d want 2", startCyc[0] - pushCyc); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %b want 1", empty); end
        checks++; if (txData !== 8'h41) begin errors++; $display("FAIL single_hold: got %h want 41", txData); end
    endtask

    task automatic test_burst;
        clearLog;
        modelLen = 87;
        for (int i = 0; i < 3; i++) begin
            tick;
            pushValid = 1'b1; pushData = 8'h61 + 8'(i);
        end
        tick;
        pushValid = 1'b0;
        for (int i = 0; i < 600 && startData.size() < 3; i++) tick;
        repeat (120) tick;
        checks++;
        if (startData.size() != 3) begin
            errors++; $display("FAIL burst_count: got %0d starts want 3", startData.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (startData[i] !== 8'h61 + 8'(i)) begin errors++; $display("FAIL burst_data%0d: got %h want %h", i, startData[i], 8'h61 + 8'(i)); end
                checks++;
                if (startPrevBusy[i] !== 1'b0) begin errors++; $display("FAIL burst_busy%0d: busy before start got %b want 0", i, startPrevBusy[i]); end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (startCyc[i] - startCyc[i-1] < 4) begin errors++; $display("FAIL burst_spacing%0d: got %0d want >=4", i, startCyc[i] - startCyc[i-1]); end
            end
        end
    endtask

    task automatic test_overflow;
        clearLog;
        modelLen = 3;
        busyForce = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick;
            pushValid = 1'b1; pushData = 8'(i);
        end
        tick;
        pushValid = 1'b0;
        @(negedge clk);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", full); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count16: got %0d want 16", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", overflow); end
        tick;
        pushValid = 1'b1; pushData = 8'h10;
        tick;
        pushValid = 1'b0;
        @(negedge clk);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count_hold: got %0d want 16", count); end
        tick;
        busyForce = 1'b0;
        for (int i = 0; i < 400 && startData.size() < 16; i++) tick;
        repeat (20) tick;
        checks++;
        if (startData.size() != 16) begin
            errors++; $display("FAIL ovf_sent: got %0d starts want 16", startData.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (startData[i] !== 8'(i)) begin errors++; $display("FAIL ovf_data%0d: got %h want %h", i, startData[i], 8'(i)); end
            end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_empty: got %b want 1", empty); end
    endtask

    task automatic test_full_pop;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        clearLog;
        modelLen = 5;
        busyForce = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick;
            pushValid = 1'b1; pushData = 8'h10 + 8'(i);
        end
        tick;
        pushValid = 1'b0;
        @(negedge clk);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fp_full: got %b want 1", full); end
        tick;
        busyForce = 1'b0;
        tick;
        checks++; if (txStart !== 1'b1) begin errors++; $display("FAIL fp_launch: got %b want 1", txStart); end
        pushValid = 1'b1; pushData = 8'hAA;
        tick;
        pushValid = 1'b0;
        @(negedge clk);
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL fp_count: got %0d want 16", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fp_overflow: got %b want 0", overflow); end
        for (int i = 0; i < 500 && startData.size() < 17; i++) tick;
        repeat (20) tick;
        checks++;
        if (startData.size() != 17) begin
            errors++; $display("FAIL fp_sent: got %0d starts want 17", startData.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (startData[i] !== 8'h10 + 8'(i)) begin errors++; $display("FAIL fp_data%0d: got %h want %h", i, startData[i], 8'h10 + 8'(i)); end
            end
            checks++; if (startData[16] !== 8'hAA) begin errors++; $display("FAIL fp_last: got %h want aa", startData[16]); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fp_empty: got %b want 1", empty); end
    endtask

    task automatic test_reset_mid;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        clearLog;
        modelLen = 87;
        for (int i = 0; i < 6; i++) begin
            tick;
            pushValid = 1'b1; pushData = 8'h30 + 8'(i);
        end
        tick;
        pushValid = 1'b0;
        repeat (8) tick;
        @(negedge clk);
        checks++; if (count !== 5'd5) begin errors++; $display("FAIL mid_count_before: got %0d want 5", count); end
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty: got %b want 1", empty); end
        clearLog;
        for (int i = 0; i < 150 && txBusy; i++) tick;
        checks++; if (txBusy !== 1'b0) begin errors++; $display("FAIL mid_busy_timeout: got %b want 0", txBusy); end
        repeat (5) tick;
        checks++; if (startData.size() != 0) begin errors++; $display("FAIL mid_no_start: got %0d starts want 0", startData.size()); end
        pushValid = 1'b1; pushData = 8'h55; pushCyc = cyc;
        tick;
        pushValid = 1'b0;
        repeat (10) tick;
        checks++;
        if (startData.size() != 1) begin
            errors++; $display("FAIL mid_restart: got %0d starts want 1", startData.size());
        end else begin
            checks++; if (startData[0] !== 8'h55) begin errors++; $display("FAIL mid_data: got %h want 55", startData[0]); end
            checks++; if (startCyc[0] - pushCyc != 2) begin errors++; $display("FAIL mid_latency: got %0d want 2", startCyc[0] - pushCyc); end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_burst;
        test_overflow;
        test_full_pop;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
